// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single outstanding reads to a
// variable-latency instruction memory and buffers returns in a 2-entry FIFO for decode.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        halted
);

    typedef enum logic [1:0] {StFetch, StWait, StHalt} state_e;

    state_e      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] req_pc_q, req_pc_d;
    logic [15:0] fifo_pc_q    [2];
    logic [15:0] fifo_instr_q [2];
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        outstanding_q, outstanding_d;
    logic        drop_q, drop_d;
    logic        halt_seen_q, halt_seen_d;
    logic        halted_q, halted_d;

    logic        resp;
    logic        enq;
    logic        deq;
    logic [15:0] redirect_target;

    assign redirect_target = redirect_pc & 16'hFFFE;

    assign if_valid    = (count_q != 2'd0);
    assign if_instr    = if_valid ? fifo_instr_q[rd_ptr_q] : 16'h0000;
    assign if_pc       = if_valid ? fifo_pc_q[rd_ptr_q] : 16'h0000;
    assign if_pc_plus2 = if_valid ? fifo_pc_q[rd_ptr_q] + 16'd2 : 16'h0000;
    assign halted      = halted_q;
    assign imem_addr   = fetch_pc_q;

    // Responses only count while a request is in flight; stray pulses are ignored.
    assign resp = outstanding_q && imem_valid;
    assign enq  = resp && !drop_q && !redirect;
    assign deq  = if_valid && if_ready && !redirect;

    assign imem_req = !rst && (state_q == StFetch) && !halt_seen_q && !redirect &&
                      (({1'b0, count_q} + {2'b00, outstanding_q}) < 3'd2);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        halt_seen_d   = halt_seen_q;
        halted_d      = halted_q;

        if (deq && (if_instr[15:12] == 4'hF)) begin
            halted_d = 1'b1;
        end

        unique case (state_q)
            StFetch: begin
                if (imem_req) begin
                    outstanding_d = 1'b1;
                    req_pc_d      = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + 16'd2;
                    state_d       = StWait;
                end
            end
            StWait: begin
                if (resp) begin
                    outstanding_d = 1'b0;
                    drop_d        = 1'b0;
                    if (enq && (imem_data[15:12] == 4'hF)) begin
                        halt_seen_d = 1'b1;
                        state_d     = StHalt;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase

        // Redirect overrides everything; a still-pending response is marked for discard.
        if (redirect) begin
            fetch_pc_d  = redirect_target;
            halt_seen_d = 1'b0;
            if (outstanding_q && !imem_valid) begin
                drop_d  = 1'b1;
                state_d = StWait;
            end else begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
                state_d       = StFetch;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (redirect) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFetch;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            halt_seen_q   <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            halt_seen_q   <= halt_seen_d;
            halted_q      <= halted_d;
            if (redirect) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (enq) begin
                    fifo_pc_q[wr_ptr_q]    <= req_pc_q;
                    fifo_instr_q[wr_ptr_q] <= imem_data;
                    wr_ptr_q               <= ~wr_ptr_q;
                end
                if (deq) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the WISC-F18 CPU. It owns the program counter and issues one read at a time to the instruction memory, which has variable latency. Returned instructions go into a 2-entry buffer that feeds decode through a valid/ready handshake. It also handles branch redirects from the PC control logic and stops fetching after a HLT instruction (opcode 4'hF).

## Interface
- RESET_PC, 16'h0000, PC loaded on reset; bit 0 must be 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  one-cycle read request pulse to instruction memory.
- imem_addr  out  16  byte address for the read; valid when imem_req=1.
- imem_valid  in  1  one-cycle pulse; imem_data holds the data for the single outstanding request.
- imem_data  in  16  instruction word returned by memory.
- redirect  in  1  branch taken; flush and refetch from redirect_pc.
- redirect_pc  in  16  redirect target; bit 0 is forced to 0.
- if_ready  in  1  decode accepts the head entry this cycle.
- if_valid  out  1  buffer head is valid.
- if_instr  out  16  head instruction; 16'h0000 when empty.
- if_pc  out  16  head instruction address; 16'h0000 when empty.
- if_pc_plus2  out  16  if_pc+2, mod 2^16; 16'h0000 when empty.
- halted  out  1  HLT has been dequeued by decode; sticky.

## Operation
- State: fetch_pc (16 bits), 2-entry FIFO of {pc, instr}, fifo count (0..2), outstanding flag, drop flag, halt_seen flag, halted flag.
- FSM states:
  - FETCH: issuing requests.
  - WAIT: a request is outstanding.
  - HALT: a HLT has been enqueued; no further requests.
- Request rule: in FETCH, assert imem_req with imem_addr=fetch_pc when both of these hold:
  - count + outstanding < 2
  - redirect=0
- On a request: set outstanding; latch req_pc=fetch_pc; fetch_pc += 2, wrapping 16'hFFFE -> 16'h0000; go to WAIT.
- Response in WAIT when imem_valid=1:
  - If drop=0 and redirect=0: enqueue {req_pc, imem_data}.
  - If imem_data[15:12]==4'hF: set halt_seen and go to HALT.
  - Otherwise return to FETCH.
  - In all cases clear outstanding and drop.
- Dequeue: when if_valid and if_ready, pop the head.
  - If the popped instruction's opcode is 4'hF, set halted.
- Redirect (any state, highest priority):
  - Flush the FIFO (count=0).
  - fetch_pc = {redirect_pc[15:1],1'b0}.
  - Clear halt_seen and return to FETCH.
  - If a request is outstanding and imem_valid=0 this cycle, set drop and stay in WAIT; the late response is discarded.
  - halted is not cleared once set.
- imem_valid while no request is outstanding is ignored.
- The FIFO never overflows because of the request rule; an enqueue while full is a design error (assertion in bench).
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=if_pc=if_pc_plus2=0, halted=0, fetch_pc=RESET_PC, FSM=FETCH.
- Reset during an outstanding request: state returns to reset values; a response arriving after reset is ignored.

## Timing
- First request is in the first cycle with rst=0, at addr RESET_PC.
- Fetch-to-decode latency: imem_valid in cycle N gives if_valid=1 in cycle N+1. Total is memory latency + 1.
- At most one request is outstanding.
- Back-to-back: with 1-cycle memory, requests go out every 2 cycles.
- Simultaneous events:
  - redirect with imem_valid: the response is dropped.
  - redirect with dequeue: the dequeue is ignored; halted is not set by it.
  - enqueue with dequeue: count unchanged.
- No imem_req in a redirect cycle; the first request to the target goes out the following cycle.
- halted rises in the cycle after HLT is dequeued.

## Test plan
- Reset, 1-cycle memory returning addr/2 as data, if_ready=1:
  - First imem_req at addr 0x0000, next at 0x0002.
  - if_instr sequence 0x0000, 0x0001, ...; if_pc_plus2 = if_pc+2.
- if_ready=0 for 10 cycles:
  - Exactly 2 requests issued, then no imem_req.
  - FIFO holds pc 0x0000 and 0x0002.
  - After release, instructions drain in order with none lost.
- Memory latency 4; redirect to 0x0101 while a request is outstanding:
  - The stale response is dropped.
  - Next request goes to 0x0100.
  - if_pc of the next delivered instruction is 0x0100.
- Memory returns 0xF000 at pc 0x0006:
  - No request after it.
  - halted=1 the cycle after decode accepts it.
  - if_valid=0 thereafter.
- HLT enqueued but not yet dequeued, then redirect to 0x0040:
  - HLT is flushed and halted stays 0.
  - Fetch resumes at 0x0040.
- RESET_PC=16'hFFFE:
  - Fetches 0xFFFE, then 0x0000 (wrap).
  - if_pc_plus2=0x0000 for the first instruction.
- Assert rst mid-WAIT, then deliver imem_valid:
  - Response ignored.
  - Outputs at reset values.
  - A fresh request goes to RESET_PC.
